// File: rtl/alu_decode_stage.sv
// RV32I decode stage feeding the ALU: decodes instr + regfile data into a registered
// ALU bundle behind a valid/ready handshake with a 2-entry (output + skid) buffer.
module alu_decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      aluop,
  output logic [XLEN-1:0] opr_a,
  output logic [XLEN-1:0] opr_b,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpSll  = 4'b0010;
  localparam logic [3:0] OpSlt  = 4'b0011;
  localparam logic [3:0] OpSltu = 4'b0100;
  localparam logic [3:0] OpXor  = 4'b0101;
  localparam logic [3:0] OpSrl  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpOr   = 4'b1000;
  localparam logic [3:0] OpAnd  = 4'b1001;

  localparam logic [6:0] F7Zero = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef struct packed {
    logic            illegal;
    logic            rd_we;
    logic [4:0]      rd_addr;
    logic [3:0]      aluop;
    logic [XLEN-1:0] opr_a;
    logic [XLEN-1:0] opr_b;
  } bundle_t;

  function automatic logic [3:0] f3_op(input logic [2:0] funct3);
    logic [3:0] op;
    unique case (funct3)
      3'b000:  op = OpAdd;
      3'b001:  op = OpSll;
      3'b010:  op = OpSlt;
      3'b011:  op = OpSltu;
      3'b100:  op = OpXor;
      3'b101:  op = OpSrl;
      3'b110:  op = OpOr;
      default: op = OpAnd;
    endcase
    return op;
  endfunction

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;
  bundle_t         dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

  always_comb begin
    dec         = '0;
    dec.rd_we   = 1'b1;
    dec.rd_addr = instr[11:7];
    dec.aluop   = OpAdd;
    dec.opr_a   = rs1_data;
    unique case (opcode)
      7'b0110011: begin
        dec.opr_b = rs2_data;
        dec.aluop = f3_op(funct3);
        if (funct7 == F7Alt && funct3 == 3'b000)      dec.aluop = OpSub;
        else if (funct7 == F7Alt && funct3 == 3'b101) dec.aluop = OpSra;
        else if (funct7 != F7Zero)                    dec.illegal = 1'b1;
      end
      7'b0010011: begin
        dec.opr_b = imm_i;
        dec.aluop = f3_op(funct3);
        // Shift immediates carry funct7 in the upper immediate bits.
        if (funct3 == 3'b001) begin
          dec.opr_b = shamt;
          if (funct7 != F7Zero) dec.illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec.opr_b = shamt;
          if (funct7 == F7Alt)        dec.aluop = OpSra;
          else if (funct7 != F7Zero)  dec.illegal = 1'b1;
        end
      end
      7'b0110111: begin
        dec.opr_a = '0;
        dec.opr_b = imm_u;
      end
      7'b0010111: begin
        dec.opr_a = pc;
        dec.opr_b = imm_u;
      end
      7'b0000011: dec.opr_b = imm_i;
      7'b0100011: begin
        dec.opr_b = imm_s;
        dec.rd_we = 1'b0;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    if (dec.rd_addr == 5'd0) dec.rd_we = 1'b0;
  end

  bundle_t out_q, skid_q;
  logic    out_valid_q, out_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    in_ready_q;
  logic    in_xfer, out_load;

  assign in_xfer  = in_valid && in_ready_q;
  // Output register may take a new bundle when empty or handing its current one off.
  assign out_load = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (out_load) begin
      out_valid_d  = skid_valid_q || in_xfer;
      skid_valid_d = 1'b0;
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
      if (out_load) begin
        if (skid_valid_q) out_q <= skid_q;
        else if (in_xfer) out_q <= dec;
      end else if (in_xfer) begin
        skid_q <= dec;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign aluop     = out_q.aluop;
  assign opr_a     = out_q.opr_a;
  assign opr_b     = out_q.opr_b;
  assign rd_addr   = out_q.rd_addr;
  assign rd_we     = out_q.rd_we;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage: decode vectors, stall/skid ordering,
// and reset while both buffer entries are occupied.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, opr_a, opr_b;
  logic [3:0]  aluop;
  logic [4:0]  rd_addr;
  logic        rd_we, illegal;

  int checks = 0;
  int errors = 0;

  alu_decode_stage #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .aluop    (aluop),
    .opr_a    (opr_a),
    .opr_b    (opr_b),
    .rd_addr  (rd_addr),
    .rd_we    (rd_we),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // {out_valid, illegal, rd_we, rd_addr, aluop, opr_a, opr_b}
  function automatic logic [75:0] obs();
    return {out_valid, illegal, rd_we, rd_addr, aluop, opr_a, opr_b};
  endfunction

  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] b);
    instr = i; pc = p; rs1_data = a; rs2_data = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, obs()} !== {1'b1, 76'd0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b %h exp rdy=1 %h", in_ready, obs(), 76'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_ops();
    logic [31:0] vi [6] = '{32'h002081B3, 32'h402081B3, 32'h4042D313, 32'hFFF00293,
                            32'h0020B233, 32'h0F00F413};
    logic [31:0] va [6] = '{32'd5, 32'd5, 32'h80000000, 32'd0, 32'd5, 32'd5};
    logic [75:0] ve [6] = '{{3'b101, 5'd3, 4'h0, 32'd5, 32'd7},
                            {3'b101, 5'd3, 4'h1, 32'd5, 32'd7},
                            {3'b101, 5'd6, 4'h7, 32'h80000000, 32'd4},
                            {3'b101, 5'd5, 4'h0, 32'd0, 32'hFFFFFFFF},
                            {3'b101, 5'd4, 4'h4, 32'd5, 32'd7},
                            {3'b101, 5'd8, 4'h9, 32'd5, 32'h000000F0}};
    for (int k = 0; k < 6; k++) begin
      send(vi[k], 32'h0, va[k], 32'd7);
      checks++;
      if (obs() !== ve[k]) begin
        errors++;
        $display("FAIL alu_op[%0d] instr=%h got %h exp %h", k, vi[k], obs(), ve[k]);
      end
    end
  endtask

  task automatic test_upper_mem();
    logic [31:0] vi [4] = '{32'h123453B7, 32'h00001097, 32'h0020A423, 32'hFFC0A483};
    logic [75:0] ve [4] = '{{3'b101, 5'd7, 4'h0, 32'd0, 32'h12345000},
                            {3'b101, 5'd1, 4'h0, 32'h100, 32'h00001000},
                            {3'b100, 5'd8, 4'h0, 32'd5, 32'd8},
                            {3'b101, 5'd9, 4'h0, 32'd5, 32'hFFFFFFFC}};
    for (int k = 0; k < 4; k++) begin
      send(vi[k], 32'h100, 32'd5, 32'd7);
      checks++;
      if (obs() !== ve[k]) begin
        errors++;
        $display("FAIL upper_mem[%0d] instr=%h got %h exp %h", k, vi[k], obs(), ve[k]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] vi [4] = '{32'h00000000, 32'h022081B3, 32'h40009093, 32'h00100013};
    logic [31:0] va [4] = '{32'd5, 32'd5, 32'd5, 32'd0};
    logic [75:0] ve [4] = '{{3'b110, 5'd0, 4'h0, 32'd0, 32'd0},
                            {3'b110, 5'd0, 4'h0, 32'd0, 32'd0},
                            {3'b110, 5'd0, 4'h0, 32'd0, 32'd0},
                            {3'b100, 5'd0, 4'h0, 32'd0, 32'd1}};
    for (int k = 0; k < 4; k++) begin
      send(vi[k], 32'h0, va[k], 32'd7);
      checks++;
      if (obs() !== ve[k]) begin
        errors++;
        $display("FAIL illegal[%0d] instr=%h got %h exp %h", k, vi[k], obs(), ve[k]);
      end
    end
  endtask

  task automatic test_stall_order();
    logic [31:0] vi [3] = '{32'h00100093, 32'h00200113, 32'h00300193};
    logic [4:0]  got_rd [3];
    logic [31:0] got_b [3];
    int          n = 0;
    int          idx = 0;
    logic        accept;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rs1_data = '0; rs2_data = '0; pc = '0;
    in_valid = 1'b1;
    instr = vi[0];
    @(posedge clk); #1;
    instr = vi[1];
    @(posedge clk); #1;
    instr = vi[2];
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready_drop got %b exp 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, rd_addr} !== {1'b0, 1'b1, 5'd1}) begin
      errors++;
      $display("FAIL stall_hold got rdy=%b vld=%b rd=%0d exp rdy=0 vld=1 rd=1",
               in_ready, out_valid, rd_addr);
    end
    out_ready = 1'b1;
    idx = 2;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && out_ready && n < 3) begin
        got_rd[n] = rd_addr;
        got_b[n] = opr_b;
        n++;
      end
      accept = in_valid && in_ready;
      @(posedge clk); #1;
      if (accept) in_valid = 1'b0;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL stall_count got %0d exp 3", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({got_rd[k], got_b[k]} !== {5'(k + 1), 32'(k + 1)}) begin
        errors++;
        $display("FAIL stall_order[%0d] got rd=%0d b=%0d exp rd=%0d b=%0d",
                 k, got_rd[k], got_b[k], k + 1, k + 1);
      end
    end
    checks++;
    if ({out_valid, in_ready} !== 2'b01 || idx != 2) begin
      errors++;
      $display("FAIL stall_drain got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    rs1_data = '0;
    in_valid = 1'b1;
    instr = 32'h00100093;
    @(posedge clk); #1;
    instr = 32'h00200113;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL full_before_reset got vld=%b rdy=%b exp vld=1 rdy=0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, obs()} !== {1'b1, 76'd0}) begin
      errors++;
      $display("FAIL reset_mid_stall got rdy=%b %h exp rdy=1 %h", in_ready, obs(), 76'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h002081B3, 32'h0, 32'd5, 32'd7);
    checks++;
    if (obs() !== {3'b101, 5'd3, 4'h0, 32'd5, 32'd7}) begin
      errors++;
      $display("FAIL after_reset_add got %h exp %h", obs(), {3'b101, 5'd3, 4'h0, 32'd5, 32'd7});
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_empty got vld=%b exp 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_upper_mem();
    test_illegal();
    test_stall_order();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Pipelined RV32I decode stage; the producer side of the ALU interface.
- Takes a fetched instruction plus register-file read data and produces registered aluop / opr_a / opr_b / writeback control for the ALU.
- Sits between fetch/regfile read and the ALU.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the ALU side can stall without a combinational ready path back to fetch.

Parameters:
XLEN, 32, datapath width of instruction, operands and PC.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream instruction valid.
in_ready  output  1  stage can accept; registered.
instr  input  32  RV32I instruction word.
pc  input  XLEN  PC of instr.
rs1_data  input  XLEN  regfile read of instr[19:15].
rs2_data  input  XLEN  regfile read of instr[24:20].
out_valid  output  1  decoded bundle valid.
out_ready  input  1  ALU/execute accepts.
aluop  output  4  ALU operation code.
opr_a  output  XLEN  ALU operand A.
opr_b  output  XLEN  ALU operand B.
rd_addr  output  5  destination register.
rd_we  output  1  writeback enable.
illegal  output  1  undecodable instruction flag.

Behaviour:
- aluop encoding, fixed:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
  - 1010-1111 are never emitted.
- Decode by opcode instr[6:0]:
  - 0110011 R-type: opr_a=rs1_data, opr_b=rs2_data.
    - funct3/funct7 select the op: 000/0000000 ADD, 000/0100000 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101/0000000 SRL, 101/0100000 SRA, 110 OR, 111 AND.
    - funct7 must be 0000000 except for SUB and SRA.
  - 0010011 I-type: opr_a=rs1_data, opr_b=sign-extended instr[31:20].
    - Same funct3 map; no SUBI.
    - Shifts: opr_b = zero-extended shamt instr[24:20]; funct7 selects SRL/SRA; any other funct7 is illegal.
  - 0110111 LUI: aluop ADD, opr_a=0, opr_b={instr[31:12],12'b0}.
  - 0010111 AUIPC: aluop ADD, opr_a=pc, opr_b={instr[31:12],12'b0}.
  - 0000011 load: ADD, opr_a=rs1_data, opr_b=sext I-imm, rd_we=1.
  - 0100011 store: ADD, opr_a=rs1_data, opr_b=sext S-imm {instr[31:25],instr[11:7]}, rd_we=0.
- rd_addr=instr[11:7] for all legal instructions; rd_we=1 for all legal non-store instructions.
- rd_we forced 0 when rd_addr==0.
- Illegal (any other opcode, or bad funct7): illegal=1, aluop=0000, opr_a=opr_b=0, rd_we=0, rd_addr=0.
  - Still handshaked through as a normal transfer.
- Handshake:
  - Input transfer when in_valid&&in_ready.
  - Output transfer when out_valid&&out_ready.
  - Output bundle is held stable while out_valid&&!out_ready.
  - Latency: 1 cycle from input transfer to out_valid when output register empty or draining.
- Buffering: main output register plus one skid register.
  - in_ready = !skid_full, registered.
  - Output stalled and new input accepted: decoded result goes to skid; in_ready drops next cycle.
  - Output transfer with skid full: skid moves to output; in_ready rises next cycle.
  - Simultaneous input and output transfer with skid empty: output register loads new decode; out_valid stays 1.
  - Ordering strictly FIFO; no drop, no duplication.
- rs1_data/rs2_data/pc sampled only at input transfer.
- Reset (async assert, sync deassert upstream):
  - out_valid=0, in_ready=1, skid empty.
  - aluop=0, opr_a=opr_b=0, rd_addr=0, rd_we=0, illegal=0.
  - Reset mid-stall discards both entries.
- Payload registers need not clear when invalid but must be 0 after reset.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle: out_valid=1, aluop=0000, opr_a=5, opr_b=7, rd_addr=3, rd_we=1.
- SUB 0x402081B3 -> aluop=0001; SRAI x6,x5,4 (0x4042D313), rs1=0x80000000 -> aluop=0111, opr_b=4, rd_addr=6.
- ADDI x5,x0,-1 (0xFFF00293) -> opr_b=0xFFFFFFFF. LUI x7,0x12345 (0x123453B7) -> opr_a=0, opr_b=0x12345000, aluop=0000.
- instr=0x00000000 -> illegal=1, rd_we=0, aluop=0000. ADDI x0,x0,1 -> rd_we=0, illegal=0.
- Stall: out_ready=0, send 3 back-to-back valid instrs -> first two accepted, in_ready=0 the cycle after the second. Release out_ready -> outputs emitted in order, no loss.
- Assert rst_n=0 mid-stall with both entries full -> out_valid=0 and in_ready=1 immediately; after release, the next instr decodes normally.
